// File: rtl/window_line_buf_pkg.sv
// window_line_buf_pkg
// Shared constants and types for the 3-tap vertical window line buffer.
//   MAX_WIDTH_DEF : default maximum active pixels per line
//   LCNT_FULL     : line count at which both stored lines hold valid data
//   TAP_LAT       : input-to-output latency of taps and syncs, in pixel clocks
package window_line_buf_pkg;

  localparam int MAX_WIDTH_DEF = 640;
  localparam int LCNT_FULL     = 2;
  localparam int TAP_LAT       = 2;

  // Lines completed since frame start, saturating at LINE_FULL.
  typedef enum logic [1:0] {
    LINE_0    = 2'd0,
    LINE_1    = 2'd1,
    LINE_FULL = 2'(LCNT_FULL)
  } lcnt_e;

  // Control carried alongside a pixel into the second pipeline stage.
  typedef struct packed {
    logic  wr;    // pixel was stored (active and inside MAX_WIDTH)
    lcnt_e lcnt;  // line count the pixel belongs to
  } s1_ctl_t;

  function automatic lcnt_e lcnt_inc(lcnt_e l);
    case (l)
      LINE_0:  return LINE_1;
      default: return LINE_FULL;
    endcase
  endfunction

endpackage

// File: rtl/window_line_buf_if.sv
// window_line_buf_if
// Raster video stream bundle: sync, data enable and luma sample.
//   vs, hs, de : vertical sync, horizontal sync, data enable
//   pixel      : Y_DEPTH-bit luma sample
// master drives the stream, slave receives it.
interface window_line_buf_if #(
  parameter int Y_DEPTH = 8
);
  logic               vs;
  logic               hs;
  logic               de;
  logic [Y_DEPTH-1:0] pixel;

  modport master (output vs, hs, de, pixel);
  modport slave  (input  vs, hs, de, pixel);
endinterface

// File: rtl/window_line_buf_ram.sv
// lb_ram_sdp
// Simple dual-port line memory: one write port, one synchronous read port,
// read latency 1. A read and write to the same address in the same cycle
// returns the old contents (read-before-write).
//   i_pclk            : clock
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i      : read request
//   rdata_o           : read data, valid the cycle after re_i
module lb_ram_sdp #(
  parameter int DW    = 8,
  parameter int AW    = 10,
  parameter int DEPTH = 640
) (
  input  logic          i_pclk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // No reset: contents before the first write of a frame are masked upstream.
  always_ff @(posedge i_pclk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/window_line_buf.sv
// window_line_buf
// Produces a 3-tap vertical window (two lines above, one line above, current)
// from a raster luma stream, with taps and syncs delayed by TAP_LAT clocks.
//   i_arst        : asynchronous active-high reset
//   i_pclk        : pixel clock
//   i_vs/i_hs/i_de: input syncs and data enable; i_vs rising = frame start
//   i_pixel       : input luma
//   o_pixel_11_01 : tap two lines above
//   o_pixel_00_01 : tap one line above
//   o_pixel_01_01 : current pixel
//   o_vs/o_hs/o_de: syncs aligned to the taps
//   o_overflow    : sticky until next frame; a line exceeded MAX_WIDTH
// Build option: define LB_BORDER_REPLICATE_EN to replicate the nearest valid
// line into taps whose lines are not yet written in the frame; otherwise
// such taps read zero.
module window_line_buf
  import window_line_buf_pkg::*;
#(
  parameter int Y_DEPTH    = 8,
  parameter int MAX_WIDTH  = MAX_WIDTH_DEF,
  parameter int ADDR_WIDTH = 10
) (
  input  logic               i_arst,
  input  logic               i_pclk,
  input  logic               i_vs,
  input  logic               i_hs,
  input  logic               i_de,
  input  logic [Y_DEPTH-1:0] i_pixel,
  output logic [Y_DEPTH-1:0] o_pixel_11_01,
  output logic [Y_DEPTH-1:0] o_pixel_00_01,
  output logic [Y_DEPTH-1:0] o_pixel_01_01,
  output logic               o_vs,
  output logic               o_hs,
  output logic               o_de,
  output logic               o_overflow
);

  // Column counter must hold MAX_WIDTH itself as the saturated value.
  localparam int CW = $clog2(MAX_WIDTH + 1);

  logic                  vs_q, de_q;
  logic [CW-1:0]         col_q, col_d, col_eff;
  lcnt_e                 lcnt_q, lcnt_d, lcnt_eff;
  logic                  ovf_q, ovf_d;
  logic                  vs_rise, de_fall, in_range, wr;
  logic [ADDR_WIDTH-1:0] addr;

  s1_ctl_t               s1_q;
  logic [Y_DEPTH-1:0]    pix1_q;
  logic [ADDR_WIDTH-1:0] addr1_q;
  logic [TAP_LAT:1][2:0] sync_q;

  logic [Y_DEPTH-1:0]    lm0_rd, lm1_rd;
  logic [Y_DEPTH-1:0]    t11_d, t00_d, t01_d, t11_q, t00_q, t01_q;

  // Stage 0: counters. A frame start acts on the current cycle's pixel, and
  // overrides a coincident line end so the next line is treated as line 0.
  always_comb begin
    vs_rise  = i_vs & ~vs_q;
    de_fall  = de_q & ~i_de;
    col_eff  = vs_rise ? '0 : col_q;
    lcnt_eff = vs_rise ? LINE_0 : lcnt_q;
    in_range = col_eff < CW'(MAX_WIDTH);
    wr       = i_de & in_range;
    addr     = ADDR_WIDTH'(col_eff);

    col_d = col_eff;
    if (de_fall)  col_d = '0;
    else if (wr)  col_d = col_eff + CW'(1);

    lcnt_d = lcnt_eff;
    if (de_fall && !vs_rise) lcnt_d = lcnt_inc(lcnt_q);

    ovf_d = vs_rise ? 1'b0 : ovf_q;
    if (i_de && !in_range) ovf_d = 1'b1;
  end

  // LM0 holds the previous line; LM1 is fed from LM0's read data one cycle
  // later, so it holds the line before that. LM1's write trails its read by
  // one column, so the two never collide within a line.
  lb_ram_sdp #(.DW(Y_DEPTH), .AW(ADDR_WIDTH), .DEPTH(MAX_WIDTH)) u_lm0 (
    .i_pclk  (i_pclk),
    .we_i    (wr),
    .waddr_i (addr),
    .wdata_i (i_pixel),
    .re_i    (wr),
    .raddr_i (addr),
    .rdata_o (lm0_rd)
  );

  lb_ram_sdp #(.DW(Y_DEPTH), .AW(ADDR_WIDTH), .DEPTH(MAX_WIDTH)) u_lm1 (
    .i_pclk  (i_pclk),
    .we_i    (s1_q.wr),
    .waddr_i (addr1_q),
    .wdata_i (lm0_rd),
    .re_i    (wr),
    .raddr_i (addr),
    .rdata_o (lm1_rd)
  );

  // Stage 1: assemble taps, masking lines not yet written this frame.
  always_comb begin
    t01_d = pix1_q;
    t00_d = lm0_rd;
    t11_d = lm1_rd;
    if (!s1_q.wr) begin
      t01_d = '0;
      t00_d = '0;
      t11_d = '0;
    end else if (s1_q.lcnt == LINE_0) begin
`ifdef LB_BORDER_REPLICATE_EN
      t00_d = pix1_q;
      t11_d = pix1_q;
`else
      t00_d = '0;
      t11_d = '0;
`endif
    end else if (s1_q.lcnt == LINE_1) begin
`ifdef LB_BORDER_REPLICATE_EN
      t11_d = lm0_rd;
`else
      t11_d = '0;
`endif
    end
  end

  always_ff @(posedge i_pclk or posedge i_arst) begin
    if (i_arst) begin
      vs_q    <= 1'b0;
      de_q    <= 1'b0;
      col_q   <= '0;
      lcnt_q  <= LINE_0;
      ovf_q   <= 1'b0;
      s1_q    <= '0;
      pix1_q  <= '0;
      addr1_q <= '0;
      sync_q  <= '0;
      t11_q   <= '0;
      t00_q   <= '0;
      t01_q   <= '0;
    end else begin
      vs_q    <= i_vs;
      de_q    <= i_de;
      col_q   <= col_d;
      lcnt_q  <= lcnt_d;
      ovf_q   <= ovf_d;
      s1_q    <= '{wr: wr, lcnt: lcnt_eff};
      pix1_q  <= i_pixel;
      addr1_q <= addr;
      sync_q[1] <= {i_vs, i_hs, i_de};
      for (int k = 2; k <= TAP_LAT; k++) sync_q[k] <= sync_q[k-1];
      t11_q   <= t11_d;
      t00_q   <= t00_d;
      t01_q   <= t01_d;
    end
  end

  assign o_pixel_11_01 = t11_q;
  assign o_pixel_00_01 = t00_q;
  assign o_pixel_01_01 = t01_q;
  assign o_vs          = sync_q[TAP_LAT][2];
  assign o_hs          = sync_q[TAP_LAT][1];
  assign o_de          = sync_q[TAP_LAT][0];
  assign o_overflow    = ovf_q;

endmodule
